// File: rtl/iopmp_cfg_sequencer.sv
// iopmp_cfg_sequencer: TL-UL host replaying a boot table of {addr,data} writes into the IOPMP reg port.
// Optional REQ/RSP watchdog is built in when IOPMP_SEQ_TIMEOUT_EN is defined.
package iopmp_seq_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_SW  = 8;
  localparam int TL_DBW = TL_DW / 8;

  localparam logic [2:0] PutFullData   = 3'h0;
  localparam logic [2:0] AccessAck     = 3'h0;
  localparam logic [2:0] AccessAckData = 3'h1;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [1:0]        a_size;
    logic [TL_SW-1:0]  a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic             d_valid;
    logic [2:0]       d_opcode;
    logic [2:0]       d_param;
    logic [1:0]       d_size;
    logic [TL_SW-1:0] d_source;
    logic [TL_DW-1:0] d_data;
    logic             d_error;
    logic             a_ready;
  } tl_d2h_t;
endpackage

module iopmp_cfg_sequencer
  import iopmp_seq_pkg::*;
#(
  parameter int unsigned      NUM_ENTRIES    = 9,
  parameter logic [TL_SW-1:0] SOURCE_ID      = 8'hE7,
  parameter int unsigned      TIMEOUT_CYCLES = 256,
  localparam int unsigned     IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic [IW-1:0]    tbl_idx_o,
  input  logic [TL_AW-1:0] tbl_addr_i,
  input  logic [TL_DW-1:0] tbl_data_i,
  output tl_h2d_t          tl_h2d_o,
  input  tl_d2h_t          tl_d2h_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [IW-1:0]    err_idx_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_REQ, S_RSP, S_DONE
  } state_e;

  state_e           r_state;
  state_e           w_next;
  logic [IW-1:0]    r_idx;
  logic [TL_AW-1:0] r_addr;
  logic [TL_DW-1:0] r_data;
  logic             r_err;
  logic [1:0]       r_code;
  logic [IW-1:0]    r_eidx;

  logic w_last;
  logic w_wait;
  logic w_tmo;
  logic w_rsp;
  logic w_rsp_err;
  logic w_unused;

  assign w_last    = (r_idx == IW'(NUM_ENTRIES - 1));
  assign w_wait    = (r_state == S_REQ) || (r_state == S_RSP);
  assign w_rsp     = (r_state == S_RSP) && tl_d2h_i.d_valid && !w_tmo;
  assign w_rsp_err = w_rsp &&
                     (tl_d2h_i.d_error || (tl_d2h_i.d_opcode != AccessAck));

`ifdef IOPMP_SEQ_TIMEOUT_EN
  logic [31:0] r_tmo;

  // FETCH always precedes REQ, so clearing here restarts the count per entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (r_state == S_FETCH) begin
      r_tmo <= '0;
    end else if (w_wait) begin
      r_tmo <= r_tmo + 32'd1;
    end
  end

  assign w_tmo    = w_wait && (r_tmo == 32'(TIMEOUT_CYCLES - 1));
  assign w_unused = ^{tl_d2h_i.d_param, tl_d2h_i.d_size,
                      tl_d2h_i.d_source, tl_d2h_i.d_data};
`else
  assign w_tmo    = 1'b0;
  assign w_unused = ^{tl_d2h_i.d_param, tl_d2h_i.d_size,
                      tl_d2h_i.d_source, tl_d2h_i.d_data,
                      w_wait, (TIMEOUT_CYCLES != 0)};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start_i) w_next = S_FETCH;
      S_FETCH: w_next = S_REQ;
      S_REQ: begin
        if (w_tmo) begin
          w_next = S_DONE;
        end else if (tl_d2h_i.a_ready) begin
          w_next = S_RSP;
        end
      end
      S_RSP: begin
        if (w_tmo) begin
          w_next = S_DONE;
        end else if (w_rsp) begin
          w_next = (w_rsp_err || w_last) ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    tl_h2d_o = '0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    unique case (r_state)
      S_FETCH: busy_o = 1'b1;
      S_REQ: begin
        busy_o             = 1'b1;
        tl_h2d_o.a_valid   = 1'b1;
        tl_h2d_o.a_opcode  = PutFullData;
        tl_h2d_o.a_param   = 3'd0;
        tl_h2d_o.a_size    = 2'b10;
        tl_h2d_o.a_mask    = '1;
        tl_h2d_o.a_source  = SOURCE_ID;
        tl_h2d_o.a_address = r_addr;
        tl_h2d_o.a_data    = r_data;
      end
      S_RSP: begin
        busy_o           = 1'b1;
        tl_h2d_o.d_ready = 1'b1;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  // Terminal check precedes increment so the index never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
      r_code <= 2'd0;
      r_eidx <= '0;
    end else begin
      if ((r_state == S_IDLE) && start_i) begin
        r_idx  <= '0;
        r_err  <= 1'b0;
        r_code <= 2'd0;
        r_eidx <= '0;
      end else if (w_tmo) begin
        r_err  <= 1'b1;
        r_code <= 2'd3;
        r_eidx <= r_idx;
      end else if (w_rsp_err) begin
        r_err  <= 1'b1;
        r_code <= tl_d2h_i.d_error ? 2'd1 : 2'd2;
        r_eidx <= r_idx;
      end else if (w_rsp && !w_last) begin
        r_idx <= r_idx + 1'b1;
      end
      if (r_state == S_FETCH) begin
        r_addr <= tbl_addr_i;
        r_data <= tbl_data_i;
      end
    end
  end

  assign tbl_idx_o  = r_idx;
  assign err_o      = r_err;
  assign err_code_o = r_code;
  assign err_idx_o  = r_eidx;

endmodule

// File: tb/tb_iopmp_cfg_sequencer.sv
// tb_iopmp_cfg_sequencer: scoreboard bench for the IOPMP config sequencer.
// Define IOPMP_SEQ_TIMEOUT_EN to also exercise the watchdog path.
module tb_iopmp_cfg_sequencer;
  import iopmp_seq_pkg::*;

  localparam int N  = 9;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [IW-1:0] tbl_idx_o;
  logic [31:0]   tbl_addr_i;
  logic [31:0]   tbl_data_i;
  tl_h2d_t       tl_h2d_o;
  tl_d2h_t       tl_d2h_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [1:0]    err_code_o;
  logic [IW-1:0] err_idx_o;

  logic       a_ready;
  logic       d_valid;
  logic       d_error;
  logic [2:0] d_opcode;

  always #5 clk = ~clk;

  iopmp_cfg_sequencer #(
    .NUM_ENTRIES   (N),
    .SOURCE_ID     (8'hE7),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .tbl_idx_o (tbl_idx_o),
    .tbl_addr_i(tbl_addr_i),
    .tbl_data_i(tbl_data_i),
    .tl_h2d_o  (tl_h2d_o),
    .tl_d2h_i  (tl_d2h_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .err_code_o(err_code_o),
    .err_idx_o (err_idx_o)
  );

  logic [31:0] t_addr [N];
  logic [31:0] t_data [N];

  initial begin
    t_addr = '{32'h0000_0000, 32'h0000_0800, 32'h0000_1000,
               32'h0000_0010, 32'h0000_0004, 32'h0000_2000,
               32'h0000_2008, 32'h0000_2010, 32'h0000_2018};
    t_data = '{32'hFFFF_0000, 32'h0000_0004, 32'h0000_0007,
               32'h0000_0001, 32'h8000_0000, 32'h2000_0000,
               32'h0000_001F, 32'h2000_4000, 32'h0000_001B};
  end

  assign tbl_addr_i = (int'(tbl_idx_o) < N) ? t_addr[tbl_idx_o] : 32'h0;
  assign tbl_data_i = (int'(tbl_idx_o) < N) ? t_data[tbl_idx_o] : 32'h0;

  assign tl_d2h_i = '{d_valid: d_valid, d_opcode: d_opcode, d_param: 3'd0,
                      d_size: 2'd2, d_source: 8'hE7, d_data: 32'h0,
                      d_error: d_error, a_ready: a_ready};

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Responder: all TL inputs change on the falling edge
  int hold     = 0;
  bit withhold = 0;
  bit late_dv  = 0;
  int err_at   = -1;
  int opc_at   = -1;
  int hs_cnt   = 0;
  bit pend     = 0;
  int pend_idx = 0;

  initial begin
    a_ready  = 1'b1;
    d_valid  = 1'b0;
    d_error  = 1'b0;
    d_opcode = 3'h0;
    forever begin
      @(negedge clk);
      d_valid  = 1'b0;
      d_error  = 1'b0;
      d_opcode = AccessAck;
      if (pend && !withhold) begin
        d_valid  = 1'b1;
        d_error  = (pend_idx == err_at);
        d_opcode = (pend_idx == opc_at) ? AccessAckData : AccessAck;
      end
      if (late_dv) begin
        d_valid = 1'b1;
        late_dv = 0;
      end
      pend = 0;
      if (tl_h2d_o.a_valid && hold > 0) begin
        a_ready = 1'b0;
        hold--;
      end else begin
        a_ready = 1'b1;
      end
      if (tl_h2d_o.a_valid && a_ready) begin
        pend     = 1;
        pend_idx = hs_cnt;
        hs_cnt++;
      end
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } a_exp_t;

  typedef struct {
    logic          err;
    logic [1:0]    code;
    logic [IW-1:0] idx;
  } d_exp_t;

  a_exp_t qa[$];
  d_exp_t qd[$];

  int          done_cnt  = 0;
  int          done_cyc  = 0;
  int          stall_cnt = 0;
  bit          st_vld    = 0;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [7:0]  st_src;

  initial begin
    a_exp_t ea;
    d_exp_t ed;
    forever begin
      @(negedge clk);
      #1;
      if (tl_h2d_o.a_valid && !a_ready) begin
        stall_cnt++;
        if (!st_vld) begin
          st_vld  = 1;
          st_addr = tl_h2d_o.a_address;
          st_data = tl_h2d_o.a_data;
          st_src  = tl_h2d_o.a_source;
        end else begin
          chk("stall_addr", tl_h2d_o.a_address, st_addr);
          chk("stall_data", tl_h2d_o.a_data, st_data);
          chk("stall_src", 32'(tl_h2d_o.a_source), 32'(st_src));
        end
      end
      if (tl_h2d_o.a_valid && a_ready) begin
        st_vld = 0;
        if (qa.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_a: addr %h data %h, none expected",
                   tl_h2d_o.a_address, tl_h2d_o.a_data);
        end else begin
          ea = qa.pop_front();
          chk("a_address", tl_h2d_o.a_address, ea.addr);
          chk("a_data", tl_h2d_o.a_data, ea.data);
          chk("a_source", 32'(tl_h2d_o.a_source), 32'hE7);
          chk("a_opcode", 32'(tl_h2d_o.a_opcode), 32'h0);
          chk("a_size", 32'(tl_h2d_o.a_size), 32'h2);
          chk("a_mask", 32'(tl_h2d_o.a_mask), 32'hF);
        end
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        if (qd.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: err %0d code %0d, none expected",
                   err_o, err_code_o);
        end else begin
          ed = qd.pop_front();
          chk("done_err", 32'(err_o), 32'(ed.err));
          chk("done_code", 32'(err_code_o), 32'(ed.code));
          if (ed.err) chk("done_idx", 32'(err_idx_o), 32'(ed.idx));
          chk("done_busy", 32'(busy_o), 32'h0);
        end
      end
    end
  end

  task automatic push_exp(input int n_a, input logic e,
                          input logic [1:0] code, input int eidx);
    a_exp_t ea;
    d_exp_t ed;
    for (int i = 0; i < n_a; i++) begin
      ea.addr = t_addr[i];
      ea.data = t_data[i];
      qa.push_back(ea);
    end
    ed.err  = e;
    ed.code = code;
    ed.idx  = eidx[IW-1:0];
    qd.push_back(ed);
  endtask

  task automatic run_seq(input int n_a, input logic e, input logic [1:0] code,
                         input int eidx, input int lat, input bit mid_start);
    int d0;
    int sc;
    bit got;
    push_exp(n_a, e, code, eidx);
    hs_cnt = 0;
    d0     = done_cnt;
    @(negedge clk);
    start_i = 1'b1;
    sc      = cyc;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_after_start", 32'(busy_o), 32'h1);
    chk("err_cleared", 32'(err_o), 32'h0);
    if (mid_start) begin
      repeat (6) @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      #2;
      if (done_cnt != d0) got = 1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: no done_o within 400 cycles");
    end else if (lat > 0) begin
      chk("latency", 32'(done_cyc - sc), 32'(lat));
    end
    repeat (4) @(negedge clk);
    chk("single_done", 32'(done_cnt - d0), 32'h1);
    chk("a_queue_drained", 32'(qa.size()), 32'h0);
    chk("idle_after_done", 32'(busy_o), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int  d0;
    bit  seen;
    repeat (3) @(negedge clk);
    chk("rst_a_valid", 32'(tl_h2d_o.a_valid), 32'h0);
    chk("rst_d_ready", 32'(tl_h2d_o.d_ready), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_code", 32'(err_code_o), 32'h0);
    chk("rst_idx", 32'(tbl_idx_o), 32'h0);
    chk("rst_err_idx", 32'(err_idx_o), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: clean 9-entry sequence, minimum latency
    run_seq(N, 1'b0, 2'd0, 0, 3 * N + 1, 0);
    chk("t1_err", 32'(err_o), 32'h0);

    // T2: d_error on entry 4 aborts the walk
    err_at = 4;
    run_seq(5, 1'b1, 2'd1, 4, 0, 0);
    err_at = -1;
    chk("t2_err_sticky", 32'(err_o), 32'h1);
    chk("t2_code", 32'(err_code_o), 32'h1);
    chk("t2_idx", 32'(err_idx_o), 32'h4);

    // T3: a_ready withheld for 5 cycles on entry 0
    hold      = 5;
    stall_cnt = 0;
    run_seq(N, 1'b0, 2'd0, 0, 3 * N + 1 + 5, 0);
    chk("t3_stall_cycles", 32'(stall_cnt), 32'h5);

    // T4: start while busy is ignored, then reset during REQ
    run_seq(N, 1'b0, 2'd0, 0, 0, 1);
    push_exp(N, 1'b0, 2'd0, 0);
    hs_cnt = 0;
    d0     = done_cnt;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (tl_h2d_o.a_valid && tbl_idx_o == 4'd2) seen = 1;
    end
    chk("t4_reached_req", 32'(seen), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_async_a_valid", 32'(tl_h2d_o.a_valid), 32'h0);
    chk("t4_async_busy", 32'(busy_o), 32'h0);
    qa.delete();
    qd.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("t4_idx_after_rst", 32'(tbl_idx_o), 32'h0);
    chk("t4_no_done", 32'(done_cnt - d0), 32'h0);
    run_seq(N, 1'b0, 2'd0, 0, 3 * N + 1, 0);

    // T5: AccessAckData on entry 2, then a clean rerun
    opc_at = 2;
    run_seq(3, 1'b1, 2'd2, 2, 0, 0);
    opc_at = -1;
    chk("t5_code", 32'(err_code_o), 32'h2);
    chk("t5_idx", 32'(err_idx_o), 32'h2);
    run_seq(N, 1'b0, 2'd0, 0, 3 * N + 1, 0);
    chk("t5_err_clear", 32'(err_o), 32'h0);

`ifdef IOPMP_SEQ_TIMEOUT_EN
    // T6: response withheld, watchdog fires after 16 wait cycles
    withhold = 1;
    run_seq(1, 1'b1, 2'd3, 0, 18, 0);
    withhold = 0;
    d0       = done_cnt;
    late_dv  = 1;
    repeat (3) @(negedge clk);
    chk("t6_late_no_done", 32'(done_cnt - d0), 32'h0);
    chk("t6_err_kept", 32'(err_o), 32'h1);
    chk("t6_code_kept", 32'(err_code_o), 32'h3);
    run_seq(N, 1'b0, 2'd0, 0, 3 * N + 1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
